// File: rtl/bus_pkg.sv
// Shared types and helpers for the external memory bus controller.
package bus_pkg;

  // Upper bound on the configurable read latency; sizes the wait counter.
  localparam int RD_LAT_MAX = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RWAIT,
    ST_DONE,
    ST_ERR
  } state_e;

  // Channel-select width: at least one bit even for a single channel.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_wait_ctr.sv
// Loadable down-counter that times the memory read latency.
module mem_bus_wait_ctr #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load on request, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// External-bus controller: CPU MAR/MBR transactions and the UART loader
// write path onto NUM_CH memory channels with a fixed read latency.
module mem_bus_ctrl
  import bus_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 8,
  parameter  int NUM_CH = 2,
  parameter  int RD_LAT = 1,
  parameter  int LD_CH  = 0,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req,
  input  logic                     i_we,
  input  logic [CH_W-1:0]          i_ch,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic                     o_ready,
  output logic                     o_done,
  output logic                     o_err,
  output logic [DATA_W-1:0]        o_rdata,
  input  logic                     i_ld_valid,
  input  logic [ADDR_W-1:0]        i_ld_addr,
  input  logic [DATA_W-1:0]        i_ld_data,
  output logic                     o_ld_ready,
  output logic [ADDR_W-1:0]        o_ld_max_addr,
  output logic [NUM_CH-1:0]        o_mem_rd,
  output logic [NUM_CH-1:0]        o_mem_wr,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_wdata,
  input  logic [NUM_CH*DATA_W-1:0] i_mem_rdata
);

  localparam int CTR_W = $clog2(RD_LAT_MAX + 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] ld_max_q, ld_max_d;
  logic              ld_q, ld_d;
  logic              ctr_load, ctr_zero;
  logic              ch_ok;
  logic [DATA_W-1:0] ch_rdata [NUM_CH];
  logic [DATA_W-1:0] sel_rdata;

  assign ch_ok = (32'(i_ch) < 32'(NUM_CH));

  // Per-channel read-data slices, masked by the latched channel select.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_rdata
    assign ch_rdata[k] = (ch_q == CH_W'(k)) ? i_mem_rdata[k*DATA_W +: DATA_W] : '0;
  end

  // OR-combine the masked slices; at most one is non-zero.
  always_comb begin
    sel_rdata = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      sel_rdata = sel_rdata | ch_rdata[k];
    end
  end

  // Transaction sequencing; the loader takes priority over the CPU in IDLE.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ld_max_d = ld_max_q;
    ld_d     = ld_q;
    ctr_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_ld_valid) begin
          state_d = ST_WR;
          ld_d    = 1'b1;
          ch_d    = CH_W'(LD_CH);
          addr_d  = i_ld_addr;
          wdata_d = i_ld_data;
          if (i_ld_addr > ld_max_q) begin
            ld_max_d = i_ld_addr;
          end
        end else if (i_req) begin
          ld_d    = 1'b0;
          ch_d    = i_ch;
          addr_d  = i_addr;
          wdata_d = i_wdata;
          if (!ch_ok) begin
            state_d = ST_ERR;
          end else if (i_we) begin
            state_d = ST_WR;
          end else begin
            state_d  = ST_RD;
            ctr_load = 1'b1;
          end
        end
      end
      ST_RD, ST_RWAIT: begin
        if (ctr_zero) begin
          state_d = ST_DONE;
          rdata_d = sel_rdata;
        end else begin
          state_d = ST_RWAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state and latched transaction fields.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ld_max_q <= '0;
      ld_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ld_max_q <= ld_max_d;
      ld_q     <= ld_d;
    end
  end

  mem_bus_wait_ctr #(
    .W(CTR_W)
  ) u_wait_ctr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (ctr_load),
    .i_val  (CTR_W'(RD_LAT - 1)),
    .o_zero (ctr_zero)
  );

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    o_mem_rd = '0;
    o_mem_wr = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) begin
        o_mem_rd[k] = (state_q == ST_RD);
        o_mem_wr[k] = (state_q == ST_WR);
      end
    end
  end

  assign o_ready       = (state_q == ST_IDLE) && !i_ld_valid;
  assign o_ld_ready    = (state_q == ST_IDLE);
  assign o_done        = ((state_q == ST_WR) && !ld_q) || (state_q == ST_DONE) || (state_q == ST_ERR);
  assign o_err         = (state_q == ST_ERR);
  assign o_rdata       = rdata_q;
  assign o_ld_max_addr = ld_max_q;
  assign o_mem_addr    = addr_q;
  assign o_mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: transaction-level reference model,
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_mem_bus_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int NUM_CH = 3;
  localparam int RD_LAT = 3;
  localparam int LD_CH  = 0;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     req, we, ld_valid;
  logic [CH_W-1:0]          ch;
  logic [ADDR_W-1:0]        addr, ld_addr;
  logic [DATA_W-1:0]        wdata, ld_data;
  logic                     o_ready, o_done, o_err, o_ld_ready;
  logic [DATA_W-1:0]        o_rdata, o_mem_wdata;
  logic [ADDR_W-1:0]        o_ld_max_addr, o_mem_addr;
  logic [NUM_CH-1:0]        o_mem_rd, o_mem_wr;
  logic [NUM_CH*DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_bus_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NUM_CH(NUM_CH),
    .RD_LAT(RD_LAT),
    .LD_CH (LD_CH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .i_we         (we),
    .i_ch         (ch),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_ready      (o_ready),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_rdata      (o_rdata),
    .i_ld_valid   (ld_valid),
    .i_ld_addr    (ld_addr),
    .i_ld_data    (ld_data),
    .o_ld_ready   (o_ld_ready),
    .o_ld_max_addr(o_ld_max_addr),
    .o_mem_rd     (o_mem_rd),
    .o_mem_wr     (o_mem_wr),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory contents: env_mem is what the attached memories hold (updated from
  // DUT strobes); mdl_mem is what the reference model says they should hold.
  logic [DATA_W-1:0] env_mem [NUM_CH][256];
  logic [DATA_W-1:0] mdl_mem [NUM_CH][256];
  int                env_due [NUM_CH];
  logic [ADDR_W-1:0] env_a   [NUM_CH];

  // Reference model: each accepted transaction is reduced to the cycle numbers
  // at which its strobe, done and read data must appear.
  int                idle_from, rd_cyc, wr_cyc, done_cyc, err_cyc, rdata_cyc, s_ch;
  logic [DATA_W-1:0] m_rdata, m_pend, m_wdata;
  logic [ADDR_W-1:0] m_addr, m_ldmax;

  task automatic model_reset();
    idle_from = 0;
    rd_cyc    = -1;
    wr_cyc    = -1;
    done_cyc  = -1;
    err_cyc   = -1;
    rdata_cyc = -1;
    s_ch      = 0;
    m_rdata   = '0;
    m_pend    = '0;
    m_wdata   = '0;
    m_addr    = '0;
    m_ldmax   = '0;
  endtask

  // Called at the edge that starts cycle cyc, with the inputs held before it.
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      if (cyc == rdata_cyc) m_rdata = m_pend;
      if (cyc - 1 >= idle_from) begin
        if (ld_valid) begin
          wr_cyc    = cyc;
          s_ch      = LD_CH;
          m_addr    = ld_addr;
          m_wdata   = ld_data;
          idle_from = cyc + 1;
          if (ld_addr > m_ldmax) m_ldmax = ld_addr;
          mdl_mem[LD_CH][ld_addr] = ld_data;
        end else if (req) begin
          m_addr  = addr;
          m_wdata = wdata;
          if (int'(ch) >= NUM_CH) begin
            done_cyc  = cyc;
            err_cyc   = cyc;
            idle_from = cyc + 1;
          end else if (we) begin
            wr_cyc    = cyc;
            s_ch      = int'(ch);
            done_cyc  = cyc;
            idle_from = cyc + 1;
            mdl_mem[ch][addr] = wdata;
          end else begin
            rd_cyc    = cyc;
            s_ch      = int'(ch);
            done_cyc  = cyc + RD_LAT;
            rdata_cyc = cyc + RD_LAT;
            m_pend    = mdl_mem[ch][addr];
            idle_from = cyc + RD_LAT + 1;
          end
        end
      end
    end
  endtask

  // Single compare process: advance the model at each edge, compare mid-cycle.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      #4;
      chk("mem_rd",  32'(o_mem_rd),  (cyc == rd_cyc) ? (32'd1 << s_ch) : 32'd0);
      chk("mem_wr",  32'(o_mem_wr),  (cyc == wr_cyc) ? (32'd1 << s_ch) : 32'd0);
      chk("done",    32'(o_done),    32'(cyc == done_cyc));
      chk("err",     32'(o_err),     32'(cyc == err_cyc));
      chk("rdata",   32'(o_rdata),   32'(m_rdata));
      chk("mem_addr", 32'(o_mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(o_mem_wdata), 32'(m_wdata));
      chk("ld_max",  32'(o_ld_max_addr), 32'(m_ldmax));
      chk("ready",   32'(o_ready),   32'((cyc >= idle_from) && !ld_valid));
      chk("ld_ready", 32'(o_ld_ready), 32'(cyc >= idle_from));
    end
  end

  // Attached memories: capture writes, return read data RD_LAT-1 cycles after
  // the strobe cycle (junk on the bus at all other times).
  initial begin
    for (int k = 0; k < NUM_CH; k++) env_due[k] = -10;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NUM_CH; k++) begin
        if (o_mem_wr[k]) env_mem[k][o_mem_addr] = o_mem_wdata;
        if (o_mem_rd[k]) begin
          env_due[k] = cyc + RD_LAT - 1;
          env_a[k]   = o_mem_addr;
        end
        mem_rdata[k*DATA_W +: DATA_W] = (env_due[k] == cyc) ? env_mem[k][env_a[k]] : DATA_W'($urandom);
      end
    end
  end

  // Present a CPU request and return at the falling edge of the accept cycle.
  task automatic cpu_op(input logic w, input logic [CH_W-1:0] c, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    req = 1'b1; we = w; ch = c; addr = a; wdata = d;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("cpu_accept_timeout", 32'(ok), 32'd1);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic ld_op(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (o_ld_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ld_accept_timeout", 32'(ok), 32'd1);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    rst = 1'b1; req = 1'b0; we = 1'b0; ch = '0; addr = '0; wdata = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int a = 0; a < 256; a++) begin
        v = DATA_W'($urandom);
        env_mem[k][a] = v;
        mdl_mem[k][a] = v;
      end
    end
    env_mem[1][8'h10] = 16'hBEEF; mdl_mem[1][8'h10] = 16'hBEEF;
    env_mem[2][8'h40] = 16'hA5A5; mdl_mem[2][8'h40] = 16'hA5A5;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset release.
    @(negedge clk); #1;
    chk("t1_ready", 32'(o_ready), 32'd1);
    chk("t1_done",  32'(o_done),  32'd0);
    chk("t1_rdata", 32'(o_rdata), 32'd0);
    chk("t1_strb",  32'({o_mem_rd, o_mem_wr}), 32'd0);
    chk("t1_ldmax", 32'(o_ld_max_addr), 32'd0);
    chk("t1_addr",  32'(o_mem_addr), 32'd0);

    // Read ch1 @0x10 with latency 3.
    cpu_op(1'b0, 2'd1, 8'h10, 16'h0000);
    chk("t2_rd_T",   32'(o_mem_rd), 32'b010);
    chk("t2_done_T", 32'(o_done), 32'd0);
    @(negedge clk);
    chk("t2_rd_T1",  32'(o_mem_rd), 32'd0);
    @(negedge clk);
    chk("t2_done_T2", 32'(o_done), 32'd0);
    @(negedge clk);
    chk("t2_done_T3",  32'(o_done), 32'd1);
    chk("t2_rdata_T3", 32'(o_rdata), 32'hBEEF);

    // Write ch0 @0xFF.
    cpu_op(1'b1, 2'd0, 8'hFF, 16'h1234);
    chk("t3_wr",    32'(o_mem_wr), 32'b001);
    chk("t3_addr",  32'(o_mem_addr), 32'hFF);
    chk("t3_wdata", 32'(o_mem_wdata), 32'h1234);
    chk("t3_done",  32'(o_done), 32'd1);

    // Loader and CPU together: loader first, CPU afterwards.
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 8'd5; ld_data = 16'h0AAA;
    req = 1'b1; we = 1'b1; ch = 2'd1; addr = 8'h20; wdata = 16'h5555;
    #1;
    chk("t4_ready_blocked", 32'(o_ready), 32'd0);
    chk("t4_ld_ready", 32'(o_ld_ready), 32'd1);
    @(negedge clk);
    chk("t4_ld_wr",    32'(o_mem_wr), 32'b001);
    chk("t4_ld_done",  32'(o_done), 32'd0);
    chk("t4_ld_addr",  32'(o_mem_addr), 32'd5);
    chk("t4_ld_ldmax", 32'(o_ld_max_addr), 32'd5);
    ld_valid = 1'b0;
    #1;
    chk("t4_busy", 32'(o_ready), 32'd0);
    @(negedge clk); #1;
    chk("t4_cpu_ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    chk("t4_cpu_wr",   32'(o_mem_wr), 32'b010);
    chk("t4_cpu_done", 32'(o_done), 32'd1);
    chk("t4_cpu_addr", 32'(o_mem_addr), 32'h20);
    req = 1'b0;
    ld_op(8'd3, 16'h0003);
    ld_op(8'd9, 16'h0009);
    @(negedge clk);
    chk("t4_ldmax_9", 32'(o_ld_max_addr), 32'd9);
    ld_op(8'hFF, 16'h00FF);
    ld_op(8'h10, 16'h0010);
    @(negedge clk);
    chk("t4_ldmax_sat", 32'(o_ld_max_addr), 32'hFF);

    // Out-of-range channel.
    cpu_op(1'b0, 2'd3, 8'h22, 16'h0000);
    chk("t5_strb",  32'({o_mem_rd, o_mem_wr}), 32'd0);
    chk("t5_done",  32'(o_done), 32'd1);
    chk("t5_err",   32'(o_err), 32'd1);
    chk("t5_rdata", 32'(o_rdata), 32'hBEEF);
    @(negedge clk);
    chk("t5_err_gone", 32'(o_err), 32'd0);

    // Reset during the wait phase of a read.
    cpu_op(1'b0, 2'd2, 8'h40, 16'h0000);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_strb",  32'({o_mem_rd, o_mem_wr}), 32'd0);
    chk("t6_done",  32'(o_done), 32'd0);
    chk("t6_rdata", 32'(o_rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_done", 32'(o_done), 32'd0);
    end
    cpu_op(1'b0, 2'd2, 8'h40, 16'h0000);
    repeat (RD_LAT) @(negedge clk);
    chk("t6_redo_done",  32'(o_done), 32'd1);
    chk("t6_redo_rdata", 32'(o_rdata), 32'hA5A5);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 149) == 0) rst = 1'b1;
      ld_valid = ($urandom_range(0, 4) == 0);
      ld_addr  = ADDR_W'($urandom);
      ld_data  = DATA_W'($urandom);
      req      = 1'($urandom_range(0, 1));
      we       = 1'($urandom_range(0, 1));
      ch       = CH_W'($urandom_range(0, 3));
      addr     = ADDR_W'($urandom_range(0, 15));
      wdata    = DATA_W'($urandom);
    end

    @(negedge clk);
    rst = 1'b0; req = 1'b0; ld_valid = 1'b0;
    repeat (RD_LAT + 3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
